data_mem_ctrl: RTL and testbench

//  Parametrised byte-addressed little-endian data memory with a valid/ready request/response handshake.

---
 rtl/data_mem_ctrl_if.sv | 27 ++
 rtl/data_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit (master) and data_mem_ctrl (slave).
// A request is taken on req_valid && req_ready; a response is consumed on rsp_valid && rsp_ready.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with byte/half/word access, wait states and post-reset clear.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of masking low address bits.
module data_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus,
    output logic            busy
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 2 ** IDX_W;
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  clr_ptr;
    logic [3:0]        wait_cnt;

    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [31:0]       mem [WORDS];

    logic              accept;
    logic              commit;
    logic              rsp_done;
    logic              req_err;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic [31:0]       ld_data;
    logic [3:0]        be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    // The first RESP cycle (rsp_valid still low) is the commit cycle, giving accept-to-response latency of 1+WAIT_CYCLES.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        busy          = 1'b0;
        accept        = 1'b0;
        commit        = 1'b0;
        rsp_done      = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_ptr == '1) state_next = IDLE;
            end
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) state_next = RESP;
            end
            RESP: begin
                if (!bus.rsp_valid) begin
                    commit = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        word_idx = lat_addr[ADDR_W-1:2];
        lane     = lat_addr[1:0];
        rd_word  = mem[word_idx];
        ld_byte  = rd_word[{lane, 3'b000} +: 8];
        ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        req_err  = (lat_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (lat_size == 2'b01 && lane[0])     req_err = 1'b1;
        if (lat_size == 2'b10 && lane != 2'b00) req_err = 1'b1;
`endif
        be      = 4'b0000;
        wr_word = lat_wdata;
        ld_data = rd_word;
        case (lat_size)
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_word = {4{lat_wdata[7:0]}};
                ld_data = {{24{ld_byte[7] & ~lat_unsigned}}, ld_byte};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{lat_wdata[15:0]}};
                ld_data = {{16{ld_half[15] & ~lat_unsigned}}, ld_half};
            end
            2'b10: begin
                be      = 4'b1111;
                wr_word = lat_wdata;
                ld_data = rd_word;
            end
            default: begin
                be      = 4'b0000;
                ld_data = 32'h0;
            end
        endcase
        if (req_err) be = 4'b0000;
    end

    // Storage has no reset; the CLEAR sweep zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= 32'h0;
        end else if (commit && lat_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr       <= '0;
            wait_cnt      <= 4'd0;
            lat_we        <= 1'b0;
            lat_size      <= 2'b00;
            lat_unsigned  <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= 32'h0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
        end else begin
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (state == WAIT)  wait_cnt <= wait_cnt + 4'd1;
            if (accept) begin
                wait_cnt     <= 4'd0;
                lat_we       <= bus.req_we;
                lat_size     <= bus.req_size;
                lat_unsigned <= bus.req_unsigned;
                lat_addr     <= bus.req_addr;
                lat_wdata    <= bus.req_wdata;
            end
            if (commit) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= req_err;
                bus.rsp_rdata <= (lat_we || req_err) ? 32'h0 : ld_data;
            end else if (rsp_done) begin
                bus.rsp_valid <= 1'b0;
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: instance a has no wait states, instance b has three.
// Expected values are hand-computed from the little-endian byte layout.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy_a;
    logic busy_b;
    int   n_checks = 0;
    int   n_fail = 0;

    data_mem_ctrl_if #(.ADDR_W(10)) a ();
    data_mem_ctrl_if #(.ADDR_W(10)) b ();

    data_mem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_a (.clk(clk), .reset(reset), .bus(a), .busy(busy_a));
    data_mem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .bus(b), .busy(busy_b));

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete transaction on instance a (sel=0) or b (sel=1), with bounded waits on both handshakes.
    task automatic apply_stimulus(input bit sel, input logic we, input logic [1:0] size, input logic uns,
                                  input logic [9:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        int n;
        if (sel) begin
            b.req_we = we; b.req_size = size; b.req_unsigned = uns; b.req_addr = addr; b.req_wdata = wdata;
            b.req_valid = 1'b1;
        end else begin
            a.req_we = we; a.req_size = size; a.req_unsigned = uns; a.req_addr = addr; a.req_wdata = wdata;
            a.req_valid = 1'b1;
        end
        n = 0;
        while (!(sel ? b.req_ready : a.req_ready) && n < 600) begin
            @(posedge clk); #1; n++;
        end
        check_output("req_ready", sel ? b.req_ready : a.req_ready, 32'd1);
        @(posedge clk); #1;
        if (sel) b.req_valid = 1'b0; else a.req_valid = 1'b0;
        n = 0;
        while (!(sel ? b.rsp_valid : a.rsp_valid) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_output("rsp_valid", sel ? b.rsp_valid : a.rsp_valid, 32'd1);
        rdata = sel ? b.rsp_rdata : a.rsp_rdata;
        err   = sel ? b.rsp_err : a.rsp_err;
        if (sel) b.rsp_ready = 1'b1; else a.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) b.rsp_ready = 1'b0; else a.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cnt;
        bit          saw_rsp;

        a.req_valid = 0; a.req_we = 0; a.req_size = 0; a.req_unsigned = 0; a.req_addr = 0; a.req_wdata = 0; a.rsp_ready = 0;
        b.req_valid = 0; b.req_we = 0; b.req_size = 0; b.req_unsigned = 0; b.req_addr = 0; b.req_wdata = 0; b.rsp_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", busy_a, 32'd1);
        check_output("reset_req_ready", a.req_ready, 32'd0);
        check_output("reset_rsp_valid", a.rsp_valid, 32'd0);
        check_output("reset_rsp_rdata", a.rsp_rdata, 32'd0);
        check_output("reset_rsp_err", a.rsp_err, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 1000) begin
            @(posedge clk); #1; cnt++;
        end
        check_output("clear_cycles", cnt, 32'd256);
        check_output("clear_busy_b", busy_b, 32'd0);
        check_output("idle_req_ready", a.req_ready, 32'd1);

        apply_stimulus(0, 0, 2'b10, 0, 10'h3FC, 32'h0, rd, er);
        check_output("load_top_cleared", rd, 32'h0000_0000);
        check_output("load_top_err", er, 32'd0);
        apply_stimulus(0, 1, 2'b00, 0, 10'h3FF, 32'h0000_00A5, rd, er);
        apply_stimulus(0, 0, 2'b10, 0, 10'h3FC, 32'h0, rd, er);
        check_output("top_byte_lane3", rd, 32'hA500_0000);

        apply_stimulus(0, 1, 2'b10, 0, 10'h010, 32'h8899_AABC, rd, er);
        check_output("store_rdata_zero", rd, 32'h0);
        check_output("store_err", er, 32'd0);
        apply_stimulus(0, 1, 2'b00, 0, 10'h011, 32'hFFFF_FF5A, rd, er);
        apply_stimulus(0, 1, 2'b01, 0, 10'h012, 32'hFFFF_1234, rd, er);
        apply_stimulus(0, 0, 2'b10, 0, 10'h010, 32'h0, rd, er);
        check_output("merged_word", rd, 32'h1234_5ABC);

        apply_stimulus(0, 0, 2'b00, 0, 10'h013, 32'h0, rd, er);
        check_output("byte_signed_pos", rd, 32'h0000_0012);
        apply_stimulus(0, 1, 2'b00, 0, 10'h013, 32'h0000_00F0, rd, er);
        apply_stimulus(0, 0, 2'b00, 0, 10'h013, 32'h0, rd, er);
        check_output("byte_signed_neg", rd, 32'hFFFF_FFF0);
        apply_stimulus(0, 0, 2'b00, 1, 10'h013, 32'h0, rd, er);
        check_output("byte_unsigned", rd, 32'h0000_00F0);
        apply_stimulus(0, 0, 2'b01, 0, 10'h012, 32'h0, rd, er);
        check_output("half_signed_neg", rd, 32'hFFFF_F034);

        apply_stimulus(1, 1, 2'b10, 0, 10'h040, 32'h1357_9BDF, rd, er);
        b.req_we = 0; b.req_size = 2'b10; b.req_unsigned = 0; b.req_addr = 10'h040; b.req_valid = 1'b1;
        check_output("b_ready_before", b.req_ready, 32'd1);
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("b_latency_low", b.rsp_valid, 32'd0);
            @(posedge clk); #1;
        end
        check_output("b_latency_rise", b.rsp_valid, 32'd1);
        check_output("b_rdata", b.rsp_rdata, 32'h1357_9BDF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("b_hold_valid", b.rsp_valid, 32'd1);
            check_output("b_hold_rdata", b.rsp_rdata, 32'h1357_9BDF);
            check_output("b_hold_ready", b.req_ready, 32'd0);
        end
        b.rsp_ready = 1'b1;
        @(posedge clk); #1;
        b.rsp_ready = 1'b0;
        check_output("b_after_rsp_valid", b.rsp_valid, 32'd0);
        check_output("b_after_req_ready", b.req_ready, 32'd1);

        b.req_we = 1; b.req_size = 2'b10; b.req_addr = 10'h020; b.req_wdata = 32'hDEAD_BEEF; b.req_valid = 1'b1;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        @(posedge clk); #1;
        check_output("b_in_wait", b.rsp_valid, 32'd0);
        reset = 1'b1;
        #1;
        check_output("b_reset_busy", busy_b, 32'd1);
        check_output("b_reset_rsp", b.rsp_valid, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        saw_rsp = 1'b0;
        while (busy_b && cnt < 1000) begin
            @(posedge clk); #1; cnt++;
            if (b.rsp_valid) saw_rsp = 1'b1;
        end
        check_output("b_reclear_cycles", cnt, 32'd256);
        check_output("b_abandoned_rsp", saw_rsp, 32'd0);
        apply_stimulus(1, 0, 2'b10, 0, 10'h020, 32'h0, rd, er);
        check_output("b_abandoned_store", rd, 32'h0000_0000);

        apply_stimulus(0, 1, 2'b10, 0, 10'h020, 32'hCAFE_F00D, rd, er);
        apply_stimulus(0, 0, 2'b10, 0, 10'h022, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_output("misaligned_word_rdata", rd, 32'h0);
        check_output("misaligned_word_err", er, 32'd1);
`else
        check_output("masked_word_rdata", rd, 32'hCAFE_F00D);
        check_output("masked_word_err", er, 32'd0);
`endif
        apply_stimulus(0, 0, 2'b01, 1, 10'h021, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_output("misaligned_half_rdata", rd, 32'h0);
        check_output("misaligned_half_err", er, 32'd1);
`else
        check_output("masked_half_rdata", rd, 32'h0000_F00D);
        check_output("masked_half_err", er, 32'd0);
`endif
        apply_stimulus(0, 0, 2'b11, 0, 10'h000, 32'h0, rd, er);
        check_output("size11_load_rdata", rd, 32'h0);
        check_output("size11_load_err", er, 32'd1);
        apply_stimulus(0, 1, 2'b11, 0, 10'h020, 32'hFFFF_FFFF, rd, er);
        check_output("size11_store_err", er, 32'd1);
        apply_stimulus(0, 0, 2'b10, 0, 10'h020, 32'h0, rd, er);
        check_output("size11_no_write", rd, 32'hCAFE_F00D);
        check_output("size11_no_write_err", er, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
